// File: rtl/regincr_pipe_pkg.sv
// Shared types for the arbitrated registered-incrementer pipeline.
// Message and tag types plus the per-stage bundle.
package regincr_pipe_pkg;

  typedef logic [7:0] msg_t;
  typedef logic       tag_t;

  localparam tag_t TAG_REQ0 = 1'b0;
  localparam tag_t TAG_REQ1 = 1'b1;

  typedef struct packed {
    logic vld;
    tag_t tag;
    msg_t data;
  } stage_t;

  function automatic msg_t incr(msg_t m);
    return m + 8'd1;
  endfunction

endpackage

// File: rtl/regincr_tag_stage.sv
// One enabled pipeline stage: carries {vld,tag} and increments data.
// Holds its contents whenever the shared advance enable is low.
module regincr_tag_stage
  import regincr_pipe_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= '{vld: d.vld, tag: d.tag, data: incr(d.data)};
    end
  end

endmodule

// File: rtl/regincr_pipe_arbiter.sv
// Two requesters share one p_nstages-deep incrementer pipeline.
// Round-robin input arbitration, global stall on head backpressure.
module regincr_pipe_arbiter
  import regincr_pipe_pkg::*;
#(
  parameter int p_nstages = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req0_val,
  output logic                           req0_rdy,
  input  logic [7:0]                     req0_msg,
  input  logic                           req1_val,
  output logic                           req1_rdy,
  input  logic [7:0]                     req1_msg,
  output logic                           resp0_val,
  input  logic                           resp0_rdy,
  output logic [7:0]                     resp0_msg,
  output logic                           resp1_val,
  input  logic                           resp1_rdy,
  output logic [7:0]                     resp1_msg,
  output logic [$clog2(p_nstages+1)-1:0] occupancy
);

  localparam int N  = p_nstages;
  localparam int OW = $clog2(p_nstages + 1);

  stage_t d [N];
  stage_t q [N];
  stage_t head;

  logic started;
  tag_t rr_ptr;
  tag_t grant;
  logic advance;
  logic any;
  logic fire;

  assign head = q[N-1];

  always_comb begin
    advance = !head.vld;
    if (head.vld) begin
      advance = (head.tag == TAG_REQ1) ? resp1_rdy : resp0_rdy;
    end
  end

  always_comb begin
    grant = TAG_REQ0;
    unique case ({req1_val, req0_val})
      2'b11:   grant = rr_ptr;
      2'b10:   grant = TAG_REQ1;
      default: grant = TAG_REQ0;
    endcase
  end

  // started keeps both rdy low in the first cycle after reset release
  assign any  = req0_val | req1_val;
  assign fire = started && advance && any;

  assign req0_rdy = fire && (grant == TAG_REQ0);
  assign req1_rdy = fire && (grant == TAG_REQ1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started <= 1'b0;
      rr_ptr  <= TAG_REQ0;
    end else begin
      started <= 1'b1;
      if (fire) begin
        rr_ptr <= ~grant;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign d[g] = '{
        vld:  fire,
        tag:  grant,
        data: (grant == TAG_REQ1) ? req1_msg : req0_msg
      };
    end else begin : g_body
      assign d[g] = q[g-1];
    end

    regincr_tag_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (advance),
      .d     (d[g]),
      .q     (q[g])
    );
  end

  assign resp0_val = head.vld && (head.tag == TAG_REQ0);
  assign resp1_val = head.vld && (head.tag == TAG_REQ1);
  assign resp0_msg = resp0_val ? head.data : '0;
  assign resp1_msg = resp1_val ? head.data : '0;

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < N; k++) begin
      occupancy = occupancy + OW'(q[k].vld);
    end
  end

endmodule
